md_unit: RTL



---
 rtl/md_if.sv | 24 ++
 rtl/md_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/md_if.sv
// Handshake and data bundle between the register-file side and md_unit.
// The master drives operands/commands; md_unit (slave) returns HI/LO and status.
interface md_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Adat;
  logic [31:0] Bdat;
  logic        wr_hi;
  logic        wr_lo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, Adat, Bdat, wr_hi, wr_lo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, Adat, Bdat, wr_hi, wr_lo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// 33-cycle latency for every op: 32 iterations plus one sign-fixup cycle.
module md_unit (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_nx;
  logic [31:0] opnd;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        dz;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        sgn;
  logic [31:0] am;
  logic [31:0] bm;
  logic [32:0] prod;
  logic [32:0] shf;
  logic        ge;
  logic [31:0] sub;
  logic [63:0] pneg;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Operand magnitudes for signed ops; unsigned ops pass through raw.
  always_comb begin
    sgn = ~bus.op[0];
    am  = (sgn && bus.Adat[31]) ? -bus.Adat : bus.Adat;
    bm  = (sgn && bus.Bdat[31]) ? -bus.Bdat : bus.Bdat;
  end

  // One iteration: shift-add (LSB first) or restoring divide (MSB first).
  always_comb begin
    prod = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    shf  = acc[63:31];
    ge   = shf >= {1'b0, opnd};
    sub  = shf[31:0] - opnd;
    if (is_div)
      acc_nx = {(ge ? sub : shf[31:0]), acc[30:0], ge};
    else
      acc_nx = {prod, acc[31:1]};
  end

  // Sign fixup and divide-by-zero override of the final result.
  always_comb begin
    pneg = -acc;
    if (is_div) begin
      res_lo = dz ? 32'hFFFF_FFFF
                  : (neg_q ? -acc[31:0] : acc[31:0]);
      res_hi = neg_r ? -acc[63:32] : acc[63:32];
    end else begin
      res_lo = neg_q ? pneg[31:0]  : acc[31:0];
      res_hi = neg_q ? pneg[63:32] : acc[63:32];
    end
  end

  // Control FSM, iteration datapath and HI/LO register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CALC;
            cnt    <= 5'd0;
            is_div <= bus.op[1];
            neg_q  <= sgn & (bus.Adat[31] ^ bus.Bdat[31]);
            neg_r  <= sgn & bus.Adat[31];
            dz     <= (bus.Bdat == 32'd0);
            if (bus.op[1]) begin
              acc  <= {32'd0, am};
              opnd <= bm;
            end else begin
              acc  <= {32'd0, bm};
              opnd <= am;
            end
          end else begin
            if (bus.wr_hi) hi_q <= bus.Adat;
            if (bus.wr_lo) lo_q <= bus.Adat;
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIXUP;
        end
        FIXUP: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
